// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma symbol, lock depth default and receiver state encoding.
// The transmit PHY imports the same package, so both ends agree on the comma value.
package phy_pkg;

    localparam logic [7:0] COM_DEFAULT     = 8'hBC;
    localparam int unsigned BC_LOCK_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

    function automatic logic is_comma(input logic [7:0] sym, input logic [7:0] com);
        return (sym == com);
    endfunction

endpackage

// File: rtl/phy_rx_lane_deser8.sv
// Serial-to-parallel front end: 8-bit shift register plus byte phase counter.
// Exposes the shift image including the current bit so decisions use the freshest byte.
module rx_deser8 (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in_1bit,
    input  logic       align,
    output logic [7:0] sr_next,
    output logic       boundary
);

    logic [7:0] sr_r;
    logic [2:0] bit_cnt_r;

    assign sr_next  = {sr_r[6:0], data_in_1bit};
    // The edge that samples bit 7 of a byte is the one where the counter already reads 7.
    assign boundary = (bit_cnt_r == 3'd7);

    // Shift register and byte phase counter; align restarts the phase on a comma hit.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            sr_r      <= 8'h00;
            bit_cnt_r <= 3'd0;
        end else begin
            sr_r <= sr_next;
            if (align) begin
                bit_cnt_r <= 3'd0;
            end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end
        end
    end

endmodule

// File: rtl/phy_rx_lane.sv
// Single-lane receiver: comma alignment, lock qualification and byte delivery.
// Idle commas are dropped once locked; only reset leaves the locked state.
module phy_rx_lane
    import phy_pkg::*;
#(
    parameter logic [7:0]  COM     = COM_DEFAULT,
    parameter int unsigned BC_LOCK = BC_LOCK_DEFAULT
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in_1bit,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [3:0] lock_cnt
);

    localparam logic [3:0] BC_LOCK_4 = 4'(BC_LOCK);

    rx_state_t  state_r;
    rx_state_t  state_next_s;
    logic [7:0] sr_next_s;
    logic       boundary_s;
    logic       align_s;
    logic       is_com_s;
    logic [3:0] lock_inc_s;
    logic [3:0] lock_cnt_r;
    logic [3:0] lock_cnt_next_s;
    logic [7:0] data_out_r;
    logic [7:0] data_out_next_s;
    logic       valid_r;
    logic       valid_next_s;
    logic       active_r;

    rx_deser8 u_deser (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .data_in_1bit (data_in_1bit),
        .align        (align_s),
        .sr_next      (sr_next_s),
        .boundary     (boundary_s)
    );

    assign is_com_s   = is_comma(sr_next_s, COM);
    assign lock_inc_s = lock_cnt_r + 4'd1;

    // Next-state and next-output decode; SEARCH is bit-granular, LOCK/ACTIVE act on byte boundaries.
    always_comb begin
        state_next_s    = state_r;
        align_s         = 1'b0;
        lock_cnt_next_s = lock_cnt_r;
        data_out_next_s = data_out_r;
        valid_next_s    = 1'b0;
        case (state_r)
            SEARCH: begin
                if (is_com_s) begin
                    align_s         = 1'b1;
                    lock_cnt_next_s = 4'd1;
                    if (BC_LOCK_4 == 4'd1) begin
                        state_next_s = ACTIVE;
                    end else begin
                        state_next_s = LOCK;
                    end
                end else begin
                    state_next_s = SEARCH;
                end
            end
            LOCK: begin
                if (boundary_s) begin
                    if (is_com_s) begin
                        lock_cnt_next_s = lock_inc_s;
                        if (lock_inc_s == BC_LOCK_4) begin
                            state_next_s = ACTIVE;
                        end else begin
                            state_next_s = LOCK;
                        end
                    end else begin
                        // The broken byte is not rescanned; searching resumes next edge.
                        lock_cnt_next_s = 4'd0;
                        state_next_s    = SEARCH;
                    end
                end else begin
                    state_next_s = LOCK;
                end
            end
            ACTIVE: begin
                if (boundary_s && !is_com_s) begin
                    data_out_next_s = sr_next_s;
                    valid_next_s    = 1'b1;
                end else begin
                    valid_next_s = 1'b0;
                end
            end
            default: begin
                state_next_s    = SEARCH;
                lock_cnt_next_s = 4'd0;
            end
        endcase
    end

    // State and output registers; active mirrors the registered state.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_r    <= SEARCH;
            lock_cnt_r <= 4'd0;
            data_out_r <= 8'h00;
            valid_r    <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            lock_cnt_r <= lock_cnt_next_s;
            data_out_r <= data_out_next_s;
            valid_r    <= valid_next_s;
            active_r   <= (state_next_s == ACTIVE);
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign active    = active_r;
    assign lock_cnt  = lock_cnt_r;

endmodule

// File: tb/tb_phy_rx_lane.sv
// Bench for phy_rx_lane: table-driven byte vectors, hand sequences for corner cases, and
// randomized streams checked every cycle against a bit-history reference model (BC_LOCK 4 and 1).
module tb_phy_rx_lane;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       din     = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, v1, a0, a1;
    logic [3:0] lc0, lc1;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    always #5 clk_32f = ~clk_32f;

    phy_rx_lane #(.COM(8'hBC), .BC_LOCK(4)) u_lane0 (
        .clk_32f(clk_32f), .reset(reset), .data_in_1bit(din),
        .data_out(d0), .valid_out(v0), .active(a0), .lock_cnt(lc0)
    );

    phy_rx_lane #(.COM(8'hBC), .BC_LOCK(1)) u_lane1 (
        .clk_32f(clk_32f), .reset(reset), .data_in_1bit(din),
        .data_out(d1), .valid_out(v1), .active(a1), .lock_cnt(lc1)
    );

    // Reference model: remembers the last 8 bits and the number of bits since the aligning comma.
    typedef struct {
        logic [7:0] hist;
        int         mode;   // 0 searching, 1 counting commas, 2 locked
        int         since;
        logic [3:0] lcnt;
        logic [7:0] dout;
        logic       vld;
        logic       act;
    } mdl_t;

    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t n;
        n.hist = 8'h00; n.mode = 0; n.since = 0; n.lcnt = 4'd0;
        n.dout = 8'h00; n.vld = 1'b0; n.act = 1'b0;
        return n;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic b, input int bcl);
        mdl_t       n;
        logic [7:0] byt;
        logic       at_byte;
        n       = m;
        byt     = {m.hist[6:0], b};
        at_byte = (((m.since + 1) % 8) == 0);
        n.hist  = byt;
        n.vld   = 1'b0;
        n.since = m.since + 1;
        if (m.mode == 0) begin
            if (byt == 8'hBC) begin
                n.since = 0;
                n.lcnt  = 4'd1;
                n.mode  = (bcl == 1) ? 2 : 1;
            end
        end else if (m.mode == 1) begin
            if (at_byte) begin
                if (byt == 8'hBC) begin
                    n.lcnt = m.lcnt + 4'd1;
                    if (int'(n.lcnt) == bcl) n.mode = 2;
                end else begin
                    n.lcnt = 4'd0;
                    n.mode = 0;
                end
            end
        end else if (at_byte && byt != 8'hBC) begin
            n.dout = byt;
            n.vld  = 1'b1;
        end
        n.act = (n.mode == 2);
        return n;
    endfunction

    task automatic check_lane(input string name, input mdl_t m, input logic [7:0] d,
                              input logic v, input logic a, input logic [3:0] lc);
        vec_cnt++;
        if (d !== m.dout || v !== m.vld || a !== m.act || lc !== m.lcnt) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d: got d=%h v=%b act=%b lc=%0d, want d=%h v=%b act=%b lc=%0d",
                     name, cyc, d, v, a, lc, m.dout, m.vld, m.act, m.lcnt);
        end
    endtask

    task automatic expect_eq(input string name, input logic [7:0] got, input logic [7:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        din = b;
        @(posedge clk_32f);
        if (reset) begin
            m0 = mdl_step(m0, b, 4);
            m1 = mdl_step(m1, b, 1);
        end else begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end
        cyc++;
        #2;
        check_lane("lane0_cycle", m0, d0, v0, a0, lc0);
        check_lane("lane1_cycle", m1, d1, v1, a1, lc1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    // Asserts reset between edges, checks the immediate clear, toggles data while held, releases.
    task automatic apply_reset(input int ncyc);
        #1;
        reset = 1'b0;
        m0 = mdl_reset();
        m1 = mdl_reset();
        #1;
        check_lane("lane0_async_reset", m0, d0, v0, a0, lc0);
        check_lane("lane1_async_reset", m1, d1, v1, a1, lc1);
        for (int i = 0; i < ncyc; i++) send_bit(1'(i));
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       rst_before;
        logic [7:0] byte_in;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_active;
        logic [3:0] exp_lock;
    } vec_t;

    vec_t tbl [16];
    int   strobe_cyc[$];

    initial begin
        tbl[0]  = '{1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd1};
        tbl[1]  = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd2};
        tbl[2]  = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd3};
        tbl[3]  = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b1, 4'd4};
        tbl[4]  = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 4'd4};
        tbl[5]  = '{1'b0, 8'h3C, 1'b1, 8'h3C, 1'b1, 4'd4};
        tbl[6]  = '{1'b0, 8'hBC, 1'b0, 8'h3C, 1'b1, 4'd4};
        tbl[7]  = '{1'b0, 8'hFF, 1'b1, 8'hFF, 1'b1, 4'd4};
        tbl[8]  = '{1'b1, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd2};
        tbl[10] = '{1'b0, 8'h55, 1'b0, 8'h00, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd1};
        tbl[12] = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd2};
        tbl[13] = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b0, 4'd3};
        tbl[14] = '{1'b0, 8'hBC, 1'b0, 8'h00, 1'b1, 4'd4};
        tbl[15] = '{1'b0, 8'h12, 1'b1, 8'h12, 1'b1, 4'd4};

        m0 = mdl_reset();
        m1 = mdl_reset();

        // Table-driven byte vectors on the BC_LOCK=4 lane.
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].rst_before) apply_reset(5);
            send_byte(tbl[i].byte_in);
            vec_cnt++;
            if (v0 !== tbl[i].exp_valid || d0 !== tbl[i].exp_data ||
                a0 !== tbl[i].exp_active || lc0 !== tbl[i].exp_lock) begin
                err_cnt++;
                $display("FAIL table[%0d] byte=%h: got v=%b d=%h act=%b lc=%0d, want v=%b d=%h act=%b lc=%0d",
                         i, tbl[i].byte_in, v0, d0, a0, lc0, tbl[i].exp_valid, tbl[i].exp_data,
                         tbl[i].exp_active, tbl[i].exp_lock);
            end
            if (v0) strobe_cyc.push_back(cyc);
        end

        // Strobe spacing for A5, 3C, (idle BC), FF, then 12.
        expect_eq("strobe_count", 8'(strobe_cyc.size()), 8'd4);
        if (strobe_cyc.size() >= 3) begin
            expect_eq("spacing_a5_3c", 8'(strobe_cyc[1] - strobe_cyc[0]), 8'd8);
            expect_eq("spacing_3c_ff", 8'(strobe_cyc[2] - strobe_cyc[1]), 8'd16);
        end

        // Reset mid-byte while locked, then a lone data byte must not strobe.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        apply_reset(4);
        send_byte(8'h77);
        expect_eq("post_reset_77_valid", {7'd0, v0}, 8'd0);
        expect_eq("post_reset_77_active", {7'd0, a0}, 8'd0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        expect_eq("relock_active", {7'd0, a0}, 8'd1);

        // Three junk bits ahead of the comma run: lock must follow the comma phase.
        apply_reset(3);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        expect_eq("junk_active", {7'd0, a0}, 8'd1);
        expect_eq("junk_lock_cnt", {4'd0, lc0}, 8'd4);
        send_byte(8'h12);
        expect_eq("junk_first_valid", {7'd0, v0}, 8'd1);
        expect_eq("junk_first_data", d0, 8'h12);

        // Single-comma lock on the BC_LOCK=1 lane.
        apply_reset(3);
        send_byte(8'hBC);
        expect_eq("lock1_active", {7'd0, a1}, 8'd1);
        expect_eq("lock1_lock_cnt", {4'd0, lc1}, 8'd1);
        expect_eq("lock1_no_strobe", {7'd0, v1}, 8'd0);
        send_byte(8'hC3);
        expect_eq("lock1_valid", {7'd0, v1}, 8'd1);
        expect_eq("lock1_data", d1, 8'hC3);

        // Random byte stream after a lock run, with occasional bit slips.
        apply_reset(2);
        for (int i = 0; i < int'($urandom_range(0, 7)); i++) send_bit(1'($urandom));
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) send_bit(1'($urandom));
            if ($urandom_range(0, 9) < 3) send_byte(8'hBC);
            else send_byte(8'($urandom));
        end

        // Fully random bits from reset, including a random comma-heavy segment.
        apply_reset(2);
        for (int i = 0; i < 400; i++) send_bit(1'($urandom));
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) send_byte(8'hBC);
            else send_byte(8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
